switch_debouncer: RTL and testbench
===================================

# switch_debouncer

Synchronises and debounces the 24 board slide switches before they reach the `switchs` I/O module in the CPU top level. It sits between the raw `switchN24` pins and the `switch_i` input of `switchs`. It also produces per-bit rise and fall pulses and a sticky "switch changed" flag, which the I/O decode can expose to software polling loops. One sample tick comes from a shared prescaler, and each bit keeps a small sample-history shift register.

## Interface
- `WIDTH`, 24: number of switch bits.
- `TICK_DIV`, 100000: clock cycles per sample tick (1 ms at 100 MHz). Must be ≥ 2.
- `STABLE_N`, 4: number of consecutive equal samples needed to accept a new level. Must be ≥ 2.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `sw_raw`, in, WIDTH: asynchronous switch pins.
- `clr_changed`, in, 1: clears `changed`.
- `sw_out`, out, WIDTH: debounced switch levels.
- `rise`, out, WIDTH: one-cycle pulse when the matching `sw_out` bit goes 0→1.
- `fall`, out, WIDTH: one-cycle pulse when the matching `sw_out` bit goes 1→0.
- `changed`, out, 1: sticky flag, set on any `sw_out` change.
- `tick`, out, 1: prescaler strobe, exported for reuse and for the testbench.

## Operation
- **Synchroniser.** Two flops per bit: `s1 <= sw_raw`, `s2 <= s1`. Only `s2` is used downstream.
- **Prescaler.**
  - Counter `cnt`, width `$clog2(TICK_DIV)`, counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` is combinational and equals `cnt == TICK_DIV-1`.
- **History register.** Per bit, `hist[STABLE_N-1:0]` updates only on `tick`: `hist <= {hist[STABLE_N-2:0], s2}`.
- **Acceptance** (evaluated on the tick edge, using the new history value `nh`):
  - `nh` all ones and `sw_out == 0`: set `sw_out <= 1` and `rise <= 1`.
  - `nh` all zeros and `sw_out == 1`: set `sw_out <= 0` and `fall <= 1`.
  - Any other case: `sw_out` holds.
- **Pulses.** `rise` and `fall` default to 0 every cycle, so each pulse lasts exactly one cycle.
- **Changed flag.**
  - `changed <= 1` when any bit of `rise` or `fall` is being set.
  - Otherwise `changed <= 0` when `clr_changed` is high.
  - A simultaneous set and clear leaves `changed` at 1 (set wins).
- **Independence.** Bits are fully independent; several bits may change on the same tick.
- **Reset behaviour.**
  - `rst` high clears `s1`, `s2`, `cnt`, `hist`, `sw_out`, `rise`, `fall` and `changed` to 0. `tick` is therefore 0 during reset.
  - Reset mid-operation discards partial histories. After release, a high switch needs a full STABLE_N ticks before `sw_out` rises, and that rise raises `rise` and `changed`.

## Timing
- **Reset values.**
  - `sw_out`, `rise`, `fall`, `changed` and `tick` are all 0.
  - `cnt` is 0, so the first `tick` falls in the cycle before rising edge TICK_DIV after release.
  - Rising edges are numbered from 1 for the first edge with `rst` low.
- **Latency.**
  - `sw_raw` to `s2`: 2 edges.
  - Acceptance happens on the STABLE_N-th tick edge that samples the new level. `sw_out`, `rise`/`fall` and `changed` update on that same edge.
  - Worst-case latency is 2 + STABLE_N·TICK_DIV cycles.
- **Glitch rejection.** Any input pulse or glitch that leaves fewer than STABLE_N consecutive equal tick samples never changes `sw_out`.
- **Prescaler wrap.** `cnt` wraps to 0 on the same edge at which `tick` was high; there is no dead cycle.
- **Sharing.** There is no combinational path from `sw_raw` to any output; `sw_out` may feed `switchs` directly.

## Test plan
Tests run with TICK_DIV=4 and STABLE_N=3, so ticks fall at edges 4, 8, 12, … after release.
- **Clean rise.** Set `sw_raw[0]=1` before edge 1 and hold it.
  - Required: `sw_out[0]` goes 1 at edge 12.
  - Required: `rise[0]` is high only in the cycle after edge 12, and `changed` goes 1 at edge 12.
- **Glitch rejection.** With bit 5 settled at 1, drive it low for 5 cycles so that exactly one tick sample sees 0.
  - Required: `sw_out[5]` stays 1, no `fall` pulse, `changed` unchanged.
- **Multi-bit fall.** With `sw_out = 24'hFFFFFF`, drive `sw_raw` to 0.
  - Required: all bits go 0 together on the third tick after `s2` changes.
  - Required: `fall = 24'hFFFFFF` for one cycle.
- **Flag priority.**
  - `clr_changed` asserted in an idle cycle: `changed` clears on the next edge.
  - `clr_changed` asserted on the acceptance edge of a new change: `changed` stays 1.
- **Reset mid-operation.** Hold `sw_raw[3]=1` and assert `rst` for one cycle after 2 of the 3 needed ticks.
  - Required: `sw_out[3]` is 0 after the reset edge.
  - Required: `sw_out[3]` goes 1 at edge 12 after release, with `rise[3]` pulsing in the following cycle and `changed` going 1.
- **Prescaler.**
  - Required: `tick` is high exactly every 4th cycle.
  - Required: `tick` is never high while `rst` is asserted.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus tick-sampled debouncer for the board slide switches.
// Produces debounced levels, per-bit edge pulses, a sticky change flag and the tick.
module switch_debouncer #(
  parameter int WIDTH    = 24,
  parameter int TICK_DIV = 100000,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clr_changed,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0]    cnt;
  logic             tick_int;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] set_hi;
  logic [WIDTH-1:0] set_lo;

  assign tick_int = (cnt == CNT_MAX);
  assign tick     = tick_int & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_int) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Each bit owns its history so bits stay fully independent.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [STABLE_N-1:0] hist;
    logic [STABLE_N-1:0] nh;

    assign nh        = {hist[STABLE_N-2:0], s2[i]};
    assign set_hi[i] = tick_int & (&nh) & ~sw_out[i];
    assign set_lo[i] = tick_int & ~(|nh) & sw_out[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        hist <= '0;
      end else if (tick_int) begin
        hist <= nh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_out  <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      sw_out <= (sw_out | set_hi) & ~set_lo;
      rise   <= set_hi;
      fall   <= set_lo;
      // A new change wins over a clear in the same cycle.
      if (|{set_hi, set_lo}) begin
        changed <= 1'b1;
      end else if (clr_changed) begin
        changed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with a run-length reference model.
// Directed scenarios followed by randomized switch activity and resets.
module tb_switch_debouncer;

  localparam int W  = 24;
  localparam int TD = 4;
  localparam int SN = 3;

  logic          clk;
  logic          rst;
  logic [W-1:0]  sw_raw;
  logic          clr_changed;
  logic [W-1:0]  sw_out;
  logic [W-1:0]  rise;
  logic [W-1:0]  fall;
  logic          changed;
  logic          tick;

  switch_debouncer #(
    .WIDTH   (W),
    .TICK_DIV(TD),
    .STABLE_N(SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .clr_changed(clr_changed),
    .sw_out     (sw_out),
    .rise       (rise),
    .fall       (fall),
    .changed    (changed),
    .tick       (tick)
  );

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic         chg;
    logic         tk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts consecutive equal tick samples per bit.
  int           m_edge;
  logic [W-1:0] m_d1, m_d2, m_out, m_samp;
  logic [W-1:0] m_runv;
  int           m_runl [W];
  logic         m_chg;

  always @(posedge clk) begin
    exp_t e;
    e.rs = '0;
    e.fl = '0;
    if (rst) begin
      m_edge = 0;
      m_d1   = '0;
      m_d2   = '0;
      m_out  = '0;
      m_runv = '0;
      m_chg  = 1'b0;
      for (int i = 0; i < W; i++) m_runl[i] = SN;
    end else begin
      m_samp = m_d2;
      m_edge++;
      if (m_edge % TD == 0) begin
        for (int i = 0; i < W; i++) begin
          if (m_samp[i] == m_runv[i]) begin
            if (m_runl[i] < SN) m_runl[i]++;
          end else begin
            m_runv[i] = m_samp[i];
            m_runl[i] = 1;
          end
          if (m_runl[i] >= SN && m_out[i] != m_runv[i]) begin
            if (m_runv[i]) e.rs[i] = 1'b1;
            else e.fl[i] = 1'b1;
            m_out[i] = m_runv[i];
          end
        end
      end
      if ((e.rs | e.fl) != '0) m_chg = 1'b1;
      else if (clr_changed) m_chg = 1'b0;
      m_d2 = m_d1;
      m_d1 = sw_raw;
    end
    e.out = m_out;
    e.chg = m_chg;
    e.tk  = !rst && (m_edge % TD == TD - 1);
    exp_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (sw_out !== e.out || rise !== e.rs || fall !== e.fl ||
          changed !== e.chg || tick !== e.tk) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t act out=%h rise=%h fall=%h chg=%b tick=%b req out=%h rise=%h fall=%h chg=%b tick=%b",
                 $time, sw_out, rise, fall, changed, tick,
                 e.out, e.rs, e.fl, e.chg, e.tk);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
  endtask

  initial begin
    int   k;
    logic [W-1:0] m;
    rst         = 1'b1;
    sw_raw      = '0;
    clr_changed = 1'b0;
    step(3);
    chk("reset_out", 32'(sw_out), 32'h0);
    chk("reset_chg", 32'(changed), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);

    // Clean rise on bit 0, released together with the raw level.
    rst    = 1'b0;
    sw_raw = 24'h000001;
    step(11);
    chk("rise_pre12", 32'(sw_out[0]), 32'h0);
    step(1);
    chk("rise_out12", 32'(sw_out[0]), 32'h1);
    chk("rise_pulse", 32'(rise[0]), 32'h1);
    chk("rise_chg", 32'(changed), 32'h1);
    step(1);
    chk("rise_end", 32'(rise[0]), 32'h0);

    // Glitch rejection on bit 5.
    sw_raw[5] = 1'b1;
    step(30);
    clr_changed = 1'b1;
    step(1);
    clr_changed = 1'b0;
    chk("idle_clear", 32'(changed), 32'h0);
    sw_raw[5] = 1'b0;
    step(5);
    sw_raw[5] = 1'b1;
    step(25);
    chk("glitch_out", 32'(sw_out[5]), 32'h1);
    chk("glitch_chg", 32'(changed), 32'h0);

    // Multi-bit fall from all ones.
    sw_raw = '1;
    step(25);
    chk("all_high", 32'(sw_out), 32'h00FFFFFF);
    sw_raw = '0;
    k = 0;
    while (fall == '0 && k < 40) begin
      step(1);
      k++;
    end
    chk("multi_fall", 32'(fall), 32'h00FFFFFF);
    chk("multi_out", 32'(sw_out), 32'h0);
    step(1);
    chk("multi_fall_end", 32'(fall), 32'h0);

    // Clear held through an acceptance edge: set wins.
    clr_changed = 1'b1;
    sw_raw[7]   = 1'b1;
    k = 0;
    while (sw_out[7] !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    chk("prio_timeout", 32'(k < 40), 32'h1);
    chk("prio_set", 32'(changed), 32'h1);
    step(1);
    chk("prio_clr", 32'(changed), 32'h0);
    clr_changed = 1'b0;

    // Reset after two of three ticks on bit 3.
    do_reset(2);
    rst    = 1'b0;
    sw_raw = 24'h000008;
    step(9);
    rst = 1'b1;
    step(1);
    chk("midrst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    chk("midrst_out", 32'(sw_out[3]), 32'h0);
    step(11);
    chk("midrst_pre12", 32'(sw_out[3]), 32'h0);
    step(1);
    chk("midrst_out12", 32'(sw_out[3]), 32'h1);
    chk("midrst_rise", 32'(rise[3]), 32'h1);
    chk("midrst_chg", 32'(changed), 32'h1);
    step(1);
    chk("midrst_end", 32'(rise[3]), 32'h0);

    // Randomized activity: alternating slow and bouncy phases.
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 400; c++) begin
        if (p % 2 == 0) m = W'($urandom & $urandom & $urandom & $urandom);
        else m = W'($urandom & $urandom);
        sw_raw      = sw_raw ^ m;
        clr_changed = ($urandom_range(0, 7) == 0);
        rst         = ($urandom_range(0, 599) == 0);
        step(1);
      end
      rst = 1'b0;
      step(40);
    end

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
